// File: rtl/hunter_pkt_pkg.sv
// Shared types and command-code table for the Hunter fan-link packet encoder.
package hunter_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef HUNTER_TX_REPEAT_EN
    , GAP
`endif
  } state_t;

  typedef enum logic [1:0] {LOW, DATA, HIGH} chip_t;

  localparam int NUM_CMDS   = 5;
  localparam int CODE_WIDTH = 7;

  localparam logic [2:0] CMD_0 = 3'd0;
  localparam logic [2:0] CMD_1 = 3'd1;
  localparam logic [2:0] CMD_2 = 3'd2;
  localparam logic [2:0] CMD_3 = 3'd3;
  localparam logic [2:0] CMD_4 = 3'd4;

  typedef struct packed {
    logic                  vld;
    logic [CODE_WIDTH-1:0] code;
  } cmd_code_t;

  function automatic cmd_code_t cmd_code(input logic [2:0] idx);
    cmd_code_t r;
    r.vld = (int'(idx) < NUM_CMDS);
    case (idx)
      CMD_0:   r.code = 7'b1001111;
      CMD_1:   r.code = 7'b1000111;
      CMD_2:   r.code = 7'b0100111;
      CMD_3:   r.code = 7'b0010111;
      CMD_4:   r.code = 7'b0001111;
      default: r.code = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hunter_chip_timer.sv
// Chip prescaler: reloads on restart and ticks on the last cycle of every chip while enabled.
module hunter_chip_timer #(
  parameter int CHIP_CYCLES = 2203,
  parameter int CTR_WIDTH   = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic en,
  output logic chip_tick
);

  localparam logic [CTR_WIDTH-1:0] LOAD = CTR_WIDTH'(CHIP_CYCLES - 1);

  logic [CTR_WIDTH-1:0] count;

  assign chip_tick = en && (count == '0);

  always_ff @(posedge clk) begin
    if (reset)                     count <= '0;
    else if (restart || chip_tick) count <= LOAD;
    else if (en)                   count <= count - 1'b1;
  end

endmodule

// File: rtl/hunter_packet_tx.sv
// Fan RF-link packet encoder: lead zeros, ID, payload, each bit sent as chips 0,bit,1.
// Define HUNTER_TX_REPEAT_EN to resend each packet REPEATS times separated by low gaps.
module hunter_packet_tx
  import hunter_pkt_pkg::*;
#(
  parameter int CHIP_CYCLES = 2203,
  parameter int CTR_WIDTH   = 12,
  parameter int ID_WIDTH    = 4,
  parameter int CMD_WIDTH   = 7,
  parameter int LEAD_BITS   = 2,
  parameter int REPEATS     = 3,
  parameter int GAP_CYCLES  = 20000
) (
  input  logic                ref_clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          cmd,
  input  logic [ID_WIDTH-1:0] id,
  output logic                ready,
  output logic                done,
  output logic                cmd_err,
  output logic                out
);

  localparam int NBITS = LEAD_BITS + ID_WIDTH + CMD_WIDTH;
  localparam int BW    = $clog2(NBITS);

  if (CHIP_CYCLES < 1 || (2 ** CTR_WIDTH) < CHIP_CYCLES || REPEATS < 1 || GAP_CYCLES < 1)
  begin : g_bad_cfg
    $error("hunter_packet_tx: invalid parameter set");
  end

  state_t           state;
  chip_t            chip;
  logic [BW-1:0]    bit_cnt;
  logic [NBITS-1:0] pkt;
  cmd_code_t        code;
  logic             restart;
  logic             chip_tick;
  logic             last_bit;

`ifdef HUNTER_TX_REPEAT_EN
  localparam int RW = $clog2(REPEATS + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic [RW-1:0] rep_cnt;
  logic [GW-1:0] gap_cnt;
`endif

  assign code     = cmd_code(cmd);
  assign last_bit = (bit_cnt == BW'(NBITS - 1));

  // ready is high exactly while idle, so it doubles as the accept qualifier
  always_comb begin
    restart = ready && start && code.vld;
`ifdef HUNTER_TX_REPEAT_EN
    if (state == GAP && gap_cnt == '0) restart = 1'b1;
`endif
  end

  hunter_chip_timer #(
    .CHIP_CYCLES (CHIP_CYCLES),
    .CTR_WIDTH   (CTR_WIDTH)
  ) u_timer (
    .clk       (ref_clk),
    .reset     (reset),
    .restart   (restart),
    .en        (state == SEND),
    .chip_tick (chip_tick)
  );

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state   <= IDLE;
      chip    <= LOW;
      bit_cnt <= '0;
      pkt     <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      cmd_err <= 1'b0;
      out     <= 1'b0;
`ifdef HUNTER_TX_REPEAT_EN
      rep_cnt <= '0;
      gap_cnt <= '0;
`endif
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (code.vld) begin
              pkt     <= {CMD_WIDTH'(code.code), id, {LEAD_BITS{1'b0}}};
              state   <= SEND;
              ready   <= 1'b0;
              chip    <= LOW;
              bit_cnt <= '0;
              out     <= 1'b0;
`ifdef HUNTER_TX_REPEAT_EN
              rep_cnt <= '0;
`endif
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        SEND: begin
          if (chip_tick) begin
            case (chip)
              LOW: begin
                // data chip must show the current bit, not the previous one
                chip <= DATA;
                out  <= pkt[bit_cnt];
              end
              DATA: begin
                chip <= HIGH;
                out  <= 1'b1;
              end
              default: begin
                chip <= LOW;
                out  <= 1'b0;
                if (!last_bit) begin
                  bit_cnt <= bit_cnt + 1'b1;
                end else begin
                  bit_cnt <= '0;
`ifdef HUNTER_TX_REPEAT_EN
                  if (rep_cnt != RW'(REPEATS - 1)) begin
                    state   <= GAP;
                    rep_cnt <= rep_cnt + 1'b1;
                    gap_cnt <= GW'(GAP_CYCLES - 1);
                  end else begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b1;
                  end
`else
                  state <= IDLE;
                  ready <= 1'b1;
                  done  <= 1'b1;
`endif
                end
              end
            endcase
          end
        end
`ifdef HUNTER_TX_REPEAT_EN
        GAP: begin
          if (gap_cnt == '0) begin
            state <= SEND;
            chip  <= LOW;
            out   <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          out   <= 1'b0;
        end
      endcase
    end
  end

endmodule
